// File: rtl/bcd_demux.sv
// Receive side of a multiplexed BCD display bus: filters the scanned digit/select pair and
// rebuilds the parallel BCD word. Optional macro BCD_DEMUX_RANGE_CHECK_EN rejects nibbles > 9.
module bcd_demux #(
  parameter int DISPLAYS_NUM      = 4,
  parameter int SETTLE_CLK_COUNT  = 3,
  parameter int TIMEOUT_CLK_COUNT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [3:0]                i_bcd_muxed,
  input  logic [DISPLAYS_NUM-1:0]   i_bcd_sel,
  output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
  output logic                      o_frame_valid,
  output logic                      o_data_valid,
  output logic                      o_stale,
  output logic                      o_error
);

  localparam int N      = DISPLAYS_NUM;
  localparam int SW     = N + 4;
  localparam int STAB_W = $clog2(SETTLE_CLK_COUNT + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CLK_COUNT);

  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CLK_COUNT);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CLK_COUNT - 1);
  localparam logic [N-1:0]      SEL_ONE  = N'(1);

  logic [SW-1:0]     sample_q, sample_d;
  logic [SW-1:0]     prev_q, prev_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              latch_q, latch_d;
  logic [N-1:0]      seen_q, seen_d;
  logic [N*4-1:0]    data_q, data_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              frame_q, frame_d;
  logic              valid_q, valid_d;
  logic              stale_q, stale_d;
  logic              error_q, error_d;

  logic [3:0]        smp_nib;
  logic [N-1:0]      smp_sel;
  logic              sel_zero;
  logic              sel_onehot;
  logic              changed;
  logic [STAB_W-1:0] held;
  logic              want_cap;
  logic              range_bad;
  logic              capture;
  logic [N-1:0]      seen_upd;
  logic              frame_done;
  logic              timeout_hit;
  logic              multi_err;

  assign smp_nib    = sample_q[SW-1 -: 4];
  assign smp_sel    = sample_q[N-1:0];
  assign sel_zero   = (smp_sel == '0);
  assign sel_onehot = !sel_zero && ((smp_sel & (smp_sel - SEL_ONE)) == '0);
  assign changed    = (sample_q != prev_q);

  // held counts how many consecutive edges the current sample has been present, including its first
  assign held = changed ? STAB_ONE : ((stab_q >= STAB_MAX) ? STAB_MAX : (stab_q + STAB_ONE));

  assign want_cap = sel_onehot && (held >= STAB_MAX) && !(latch_q && !changed);

`ifdef BCD_DEMUX_RANGE_CHECK_EN
  assign range_bad = (smp_nib > 4'd9);
`else
  assign range_bad = 1'b0;
`endif

  assign capture     = want_cap && !range_bad;
  assign seen_upd    = seen_q | smp_sel;
  assign frame_done  = capture && (&seen_upd);
  assign timeout_hit = !capture && (to_q == TO_LAST);
  assign multi_err   = !sel_zero && !sel_onehot && changed;

  assign sample_d = {i_bcd_muxed, i_bcd_sel};
  assign prev_d   = sample_q;
  assign stab_d   = sel_onehot ? held : '0;
  assign latch_d  = want_cap ? 1'b1 : ((sel_onehot && !changed) ? latch_q : 1'b0);

  // Digit k lives in nibble k, so sel bit 0 lands in the least significant nibble
  always_comb begin
    data_d = data_q;
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        if (smp_sel[k]) data_d[4*k +: 4] = smp_nib;
      end
    end
  end

  always_comb begin
    seen_d = seen_q;
    if (capture) seen_d = frame_done ? '0 : seen_upd;
    else if (timeout_hit) seen_d = '0;
  end

  // The timeout counter parks at its last value so o_stale stays asserted until a capture
  assign to_d    = capture ? '0 : (timeout_hit ? to_q : (to_q + TO_ONE));
  assign stale_d = capture ? 1'b0 : (timeout_hit ? 1'b1 : stale_q);
  assign valid_d = frame_done ? 1'b1 : (timeout_hit ? 1'b0 : valid_q);
  assign frame_d = frame_done;
  assign error_d = multi_err || (want_cap && range_bad);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sample_q <= '0;
      prev_q   <= '0;
      stab_q   <= '0;
      latch_q  <= 1'b0;
      seen_q   <= '0;
      data_q   <= '0;
      to_q     <= '0;
      frame_q  <= 1'b0;
      valid_q  <= 1'b0;
      stale_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
      stab_q   <= stab_d;
      latch_q  <= latch_d;
      seen_q   <= seen_d;
      data_q   <= data_d;
      to_q     <= to_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      stale_q  <= stale_d;
      error_q  <= error_d;
    end
  end

  assign o_bcd_data    = data_q;
  assign o_frame_valid = frame_q;
  assign o_data_valid  = valid_q;
  assign o_stale       = stale_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_bcd_demux.sv
// Bench for bcd_demux: directed scenarios followed by random scans, all checked against a
// history-based reference model of the display bus.
module tb_bcd_demux;

  localparam int N      = 4;
  localparam int SETTLE = 3;
  localparam int TMO    = 64;
  localparam int W      = N*4 + 4;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   muxed;
  logic [N-1:0] sel;
  logic [N*4-1:0] o_bcd_data;
  logic o_frame_valid, o_data_valid, o_stale, o_error;

  always #5 clk = ~clk;

  bcd_demux #(.DISPLAYS_NUM(N), .SETTLE_CLK_COUNT(SETTLE), .TIMEOUT_CLK_COUNT(TMO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_bcd_muxed  (muxed),
    .i_bcd_sel    (sel),
    .o_bcd_data   (o_bcd_data),
    .o_frame_valid(o_frame_valid),
    .o_data_valid (o_data_valid),
    .o_stale      (o_stale),
    .o_error      (o_error)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int frame_seen  = 0;
  string step     = "init";

  // reference model state: history of sampled bus values
  logic [7:0] last_in;
  int         run;
  bit         done;
  logic [3:0] m_slot [N];
  bit         m_seen [N];
  int         since;
  bit         m_valid, m_stale;

  task automatic model_step(input logic r, input logic [3:0] m, input logic [N-1:0] s);
    logic [3:0]   lm;
    logic [N-1:0] ls;
    logic [N*4-1:0] d;
    bit cap, frame, err, all_seen;
    int k;
    frame = 0; err = 0; cap = 0; k = 0;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_slot[i] = 4'h0; m_seen[i] = 0; end
      last_in = 8'h00; run = 1; done = 0; since = 0; m_valid = 0; m_stale = 0;
    end else begin
      lm = last_in[7:4];
      ls = last_in[N-1:0];
      if ($countones(ls) > 1 && run == 1) err = 1;
      if ($countones(ls) == 1 && run >= SETTLE && !done) begin
        done = 1;
        if (RC && lm > 4'd9) err = 1;
        else cap = 1;
      end
      if (cap) begin
        for (int i = 0; i < N; i++) if (ls[i]) k = i;
        m_slot[k] = lm;
        m_seen[k] = 1;
        all_seen = 1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all_seen = 0;
        if (all_seen) begin
          frame = 1; m_valid = 1;
          for (int i = 0; i < N; i++) m_seen[i] = 0;
        end
        since = 0; m_stale = 0;
      end else begin
        if (since < TMO) since++;
        if (since >= TMO) begin
          m_stale = 1; m_valid = 0;
          for (int i = 0; i < N; i++) m_seen[i] = 0;
        end
      end
      if ({m, s} == last_in) run++;
      else begin run = 1; done = 0; end
      last_in = {m, s};
    end
    for (int i = 0; i < N; i++) d[4*i +: 4] = m_slot[i];
    exp_q.push_back({d, frame, m_valid, m_stale, err});
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %h expected %h", step, tag, obs, exp);
    end
  endtask

  // driver: one clock with the given inputs, then compare against the model at the negedge
  task automatic apply(input logic r, input logic [3:0] m, input logic [N-1:0] s);
    logic [W-1:0] e;
    rst = r; muxed = m; sel = s;
    @(posedge clk);
    model_step(r, m, s);
    @(negedge clk);
    e = exp_q.pop_front();
    check("data",  o_bcd_data,           e[W-1:4]);
    check("frame", {15'h0, o_frame_valid}, {15'h0, e[3]});
    check("valid", {15'h0, o_data_valid},  {15'h0, e[2]});
    check("stale", {15'h0, o_stale},       {15'h0, e[1]});
    check("error", {15'h0, o_error},       {15'h0, e[0]});
    if (o_error) err_seen++;
    if (o_frame_valid) frame_seen++;
  endtask

  task automatic hold(input logic [3:0] m, input logic [N-1:0] s, input int n);
    for (int i = 0; i < n; i++) apply(1'b0, m, s);
  endtask

  initial begin
    logic [N-1:0] rs;
    int kind;

    step = "reset";
    apply(1'b1, 4'h0, '0);
    apply(1'b1, 4'h0, '0);
    check("rst_data", o_bcd_data, 16'h0000);
    check("rst_flags", {12'h0, o_frame_valid, o_data_valid, o_stale, o_error}, 16'h0000);

    step = "scan";
    frame_seen = 0;
    hold(4'd1, 4'b0001, 10);
    hold(4'd2, 4'b0010, 10);
    hold(4'd3, 4'b0100, 10);
    hold(4'd4, 4'b1000, 10);
    check("word", o_bcd_data, 16'h4321);
    check("frames", 16'(frame_seen), 16'd1);
    check("dvalid", {15'h0, o_data_valid}, 16'h0001);

    step = "stale";
    hold(4'd0, 4'b0000, 70);
    check("stale_set", {15'h0, o_stale}, 16'h0001);
    check("stale_dv", {15'h0, o_data_valid}, 16'h0000);
    check("stale_word", o_bcd_data, 16'h4321);
    hold(4'd1, 4'b0001, 4);
    check("stale_clr", {15'h0, o_stale}, 16'h0000);

    step = "resettle";
    hold(4'd7, 4'b0001, 2);
    hold(4'd8, 4'b0001, 5);
    check("slot0", o_bcd_data, 16'h4328);

    step = "multihot";
    err_seen = 0;
    hold(4'd5, 4'b0011, 5);
    check("err_pulses", 16'(err_seen), 16'd1);
    check("mh_word", o_bcd_data, 16'h4328);

    step = "midreset";
    hold(4'd5, 4'b0001, 10);
    hold(4'd6, 4'b0010, 10);
    apply(1'b1, 4'd0, '0);
    check("mr_data", o_bcd_data, 16'h0000);
    check("mr_flags", {12'h0, o_frame_valid, o_data_valid, o_stale, o_error}, 16'h0000);
    frame_seen = 0;
    hold(4'd9, 4'b0001, 10);
    hold(4'd8, 4'b0010, 10);
    hold(4'd7, 4'b0100, 10);
    hold(4'd6, 4'b1000, 10);
    check("mr_frames", 16'(frame_seen), 16'd1);
    check("mr_word", o_bcd_data, 16'h6789);

    step = "range";
    apply(1'b1, 4'd0, '0);
    err_seen = 0;
    hold(4'hC, 4'b0100, 5);
    check("rng_word", o_bcd_data, RC ? 16'h0000 : 16'h0C00);
    check("rng_err", 16'(err_seen), RC ? 16'd1 : 16'd0);

    step = "random";
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 99);
      if (kind < 60) begin
        rs = N'(1) << $urandom_range(0, N-1);
        hold(4'($urandom_range(0, 15)), rs, $urandom_range(1, 6));
      end else if (kind < 80) begin
        hold(4'($urandom_range(0, 15)), '0, $urandom_range(1, 6));
      end else if (kind < 95) begin
        rs = 4'($urandom_range(0, 15));
        while ($countones(rs) < 2) rs = 4'($urandom_range(0, 15));
        hold(4'($urandom_range(0, 15)), rs, $urandom_range(1, 4));
      end else if (kind < 98) begin
        apply(1'b1, 4'd0, '0);
      end else begin
        hold(4'd0, '0, $urandom_range(60, 70));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
